amo_bank_arbiter: RTL and testbench

Round-robin arbiter that shares one atomic-capable SRAM bank port among `NumIn` requesters. It sits directly in front of the bank's AMO shim and forwards one request per cycle. It blocks all grants during the shim's AMO write-back cycle, then routes the one-cycle-latency read response back to the requester that was granted.

---
 rtl/amo_bank_arbiter.sv | 113 +++++++++++
 tb/tb_amo_bank_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/amo_bank_arbiter.sv
// Round-robin arbiter sharing one AMO-capable SRAM bank port among NumIn requesters.
// Grants stall for one cycle after an AMO so the shim can write back; responses route to the granted port.
module amo_bank_arbiter #(
    parameter int unsigned NumIn        = 4,
    parameter int unsigned AddrMemWidth = 32,
    parameter int unsigned DataWidth    = 32
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NumIn-1:0]                      req_i,
    output logic [NumIn-1:0]                      gnt_o,
    input  logic [NumIn-1:0][AddrMemWidth-1:0]    add_i,
    input  logic [NumIn-1:0][3:0]                 amo_i,
    input  logic [NumIn-1:0]                      wen_i,
    input  logic [NumIn-1:0][DataWidth-1:0]       wdata_i,
    input  logic [NumIn-1:0][DataWidth/8-1:0]     be_i,
    output logic [NumIn-1:0]                      vld_o,
    output logic [DataWidth-1:0]                  rdata_o,
    output logic                                  out_req_o,
    input  logic                                  out_gnt_i,
    output logic [AddrMemWidth-1:0]               out_add_o,
    output logic [3:0]                            out_amo_o,
    output logic                                  out_wen_o,
    output logic [DataWidth-1:0]                  out_wdata_o,
    output logic [DataWidth/8-1:0]                out_be_o,
    input  logic [DataWidth-1:0]                  out_rdata_i
);

    localparam int unsigned IdxW = (NumIn > 1) ? $clog2(NumIn) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumIn - 1);

    typedef enum logic {
        Idle,
        AmoWait
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] rr_q;
    logic [IdxW-1:0] rr_next;
    logic            rsp_vld_q;
    logic [IdxW-1:0] rsp_idx_q;
    logic [IdxW-1:0] winner;
    logic [IdxW-1:0] cand;
    logic            found;
    logic            transfer;

    // First requester at or after the round-robin pointer, wrapping at NumIn.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < NumIn; i++) begin
            cand = IdxW'((32'(rr_q) + i) % NumIn);
            if (!found && req_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign out_req_o   = (state_q == Idle) && (|req_i);
    assign transfer    = out_req_o && out_gnt_i;
    assign out_add_o   = add_i[winner];
    assign out_amo_o   = amo_i[winner];
    assign out_wen_o   = wen_i[winner];
    assign out_wdata_o = wdata_i[winner];
    assign out_be_o    = be_i[winner];
    assign rr_next     = (winner == LastIdx) ? '0 : winner + 1'b1;
    assign rdata_o     = out_rdata_i;

    always_comb begin
        gnt_o = '0;
        if (transfer) begin
            gnt_o[winner] = 1'b1;
        end
    end

    always_comb begin
        vld_o            = '0;
        vld_o[rsp_idx_q] = rsp_vld_q;
    end

    // AmoWait is a single bubble cycle that always returns to Idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            Idle: begin
                if (transfer && (amo_i[winner] != 4'd0)) begin
                    state_d = AmoWait;
                end
            end
            AmoWait: state_d = Idle;
            default: state_d = Idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= Idle;
            rr_q      <= '0;
            rsp_vld_q <= 1'b0;
            rsp_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            rsp_vld_q <= transfer;
            if (transfer) begin
                rr_q      <= rr_next;
                rsp_idx_q <= winner;
            end
        end
    end

endmodule

// File: tb/tb_amo_bank_arbiter.sv
// Directed bench for amo_bank_arbiter: a small shim/memory model answers grants,
// expected responses are queued at grant time and compared one cycle later.
module tb_amo_bank_arbiter;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b1;
    logic [3:0]        req_i = '0;
    logic [3:0]        gnt_o;
    logic [3:0][31:0]  add_i = '0;
    logic [3:0][3:0]   amo_i = '0;
    logic [3:0]        wen_i = '0;
    logic [3:0][31:0]  wdata_i = '0;
    logic [3:0][3:0]   be_i = '1;
    logic [3:0]        vld_o;
    logic [31:0]       rdata_o;
    logic              out_req_o;
    logic              out_gnt_i = 1'b1;
    logic [31:0]       out_add_o;
    logic [3:0]        out_amo_o;
    logic              out_wen_o;
    logic [31:0]       out_wdata_o;
    logic [3:0]        out_be_o;
    logic [31:0]       out_rdata_i;

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] data;
        logic        check_data;
    } rsp_t;

    rsp_t        sb[$];
    int          num_checks = 0;
    int          num_fails = 0;
    logic [31:0] mem [0:255];

    amo_bank_arbiter #(.NumIn(4), .AddrMemWidth(32), .DataWidth(32)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .add_i       (add_i),
        .amo_i       (amo_i),
        .wen_i       (wen_i),
        .wdata_i     (wdata_i),
        .be_i        (be_i),
        .vld_o       (vld_o),
        .rdata_o     (rdata_o),
        .out_req_o   (out_req_o),
        .out_gnt_i   (out_gnt_i),
        .out_add_o   (out_add_o),
        .out_amo_o   (out_amo_o),
        .out_wen_o   (out_wen_o),
        .out_wdata_o (out_wdata_o),
        .out_be_o    (out_be_o),
        .out_rdata_i (out_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Shim model: read data one cycle after grant; AMO swap (1) / add (2) and stores update memory.
    always @(posedge clk_i) begin
        if (out_req_o && out_gnt_i) begin
            out_rdata_i <= mem[out_add_o[7:0]];
            if (out_amo_o == 4'd1) begin
                mem[out_add_o[7:0]] <= out_wdata_o;
            end else if (out_amo_o == 4'd2) begin
                mem[out_add_o[7:0]] <= mem[out_add_o[7:0]] + out_wdata_o;
            end else if (out_wen_o) begin
                mem[out_add_o[7:0]] <= out_wdata_o;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_checks++;
        assert (observed === expected) else begin
            num_fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int p, input logic r, input logic [31:0] addr,
                                 input logic [3:0] amo, input logic wen, input logic [31:0] wdata);
        req_i[p]   = r;
        add_i[p]   = addr;
        amo_i[p]   = amo;
        wen_i[p]   = wen;
        wdata_i[p] = wdata;
    endtask

    task automatic clearAll();
        for (int p = 0; p < 4; p++) begin
            applyStimulus(p, 1'b0, 32'h0, 4'd0, 1'b0, 32'h0);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    // Checks grant/request now, pops last cycle's expected response, optionally queues this cycle's.
    task automatic checkCycle(input string tag, input logic [3:0] exp_gnt, input logic exp_req,
                              input logic [31:0] exp_data, input logic push_rsp, input logic check_data);
        rsp_t r;
        checkOutput({tag, ".gnt"}, {28'h0, gnt_o}, {28'h0, exp_gnt});
        checkOutput({tag, ".req"}, {31'h0, out_req_o}, {31'h0, exp_req});
        if (sb.size() > 0) begin
            r = sb.pop_front();
            checkOutput({tag, ".vld"}, {28'h0, vld_o}, {28'h0, r.mask});
            if (r.check_data) begin
                checkOutput({tag, ".rdata"}, rdata_o, r.data);
            end
        end else begin
            checkOutput({tag, ".vld_idle"}, {28'h0, vld_o}, 32'h0);
        end
        if (push_rsp) begin
            sb.push_back('{mask: exp_gnt, data: exp_data, check_data: check_data});
        end
    endtask

    task automatic cycle(input string tag, input logic [3:0] exp_gnt, input logic exp_req,
                         input logic [31:0] exp_data, input logic push_rsp, input logic check_data);
        @(negedge clk_i);
        checkCycle(tag, exp_gnt, exp_req, exp_data, push_rsp, check_data);
        nextCycle();
    endtask

    task automatic doReset();
        clearAll();
        rst_ni = 1'b0;
        @(negedge clk_i);
        checkOutput("reset.vld", {28'h0, vld_o}, 32'h0);
        checkOutput("reset.req", {31'h0, out_req_o}, 32'h0);
        nextCycle();
        rst_ni = 1'b1;
        sb.delete();
    endtask

    initial begin
        #1;
        doReset();

        // Preload memory through the arbiter with stores.
        applyStimulus(0, 1'b1, 32'h10, 4'd0, 1'b1, 32'hDEADBEEF);
        cycle("pre0", 4'b0001, 1'b1, 32'h0, 1'b1, 1'b0);
        applyStimulus(0, 1'b1, 32'h20, 4'd0, 1'b1, 32'd7);
        cycle("pre1", 4'b0001, 1'b1, 32'h0, 1'b1, 1'b0);
        applyStimulus(0, 1'b1, 32'h30, 4'd0, 1'b1, 32'd0);
        cycle("pre2", 4'b0001, 1'b1, 32'h0, 1'b1, 1'b0);
        clearAll();
        cycle("pre3", 4'b0000, 1'b0, 32'h0, 1'b0, 1'b0);

        // Single load.
        doReset();
        applyStimulus(0, 1'b1, 32'h10, 4'd0, 1'b0, 32'h0);
        @(negedge clk_i);
        checkOutput("load.addr", out_add_o, 32'h10);
        checkCycle("load0", 4'b0001, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
        nextCycle();
        clearAll();
        cycle("load1", 4'b0000, 1'b0, 32'h0, 1'b0, 1'b0);

        // Fairness from reset.
        doReset();
        for (int p = 0; p < 4; p++) begin
            applyStimulus(p, 1'b1, 32'h10, 4'd0, 1'b0, 32'h0);
        end
        cycle("fair0", 4'b0001, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
        cycle("fair1", 4'b0010, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
        cycle("fair2", 4'b0100, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
        cycle("fair3", 4'b1000, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
        cycle("fair4", 4'b0001, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
        clearAll();
        cycle("fair5", 4'b0000, 1'b0, 32'h0, 1'b0, 1'b0);

        // AMO bubble: pointer is 1, port 1 AMOAdd 5 on 7, port 2 load of same word.
        applyStimulus(1, 1'b1, 32'h20, 4'd2, 1'b0, 32'd5);
        applyStimulus(2, 1'b1, 32'h20, 4'd0, 1'b0, 32'h0);
        @(negedge clk_i);
        checkOutput("amo.op", {28'h0, out_amo_o}, 32'd2);
        checkOutput("amo.operand", out_wdata_o, 32'd5);
        checkCycle("amo0", 4'b0010, 1'b1, 32'd7, 1'b1, 1'b1);
        nextCycle();
        applyStimulus(1, 1'b0, 32'h0, 4'd0, 1'b0, 32'h0);
        cycle("amo1", 4'b0000, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle("amo2", 4'b0100, 1'b1, 32'd12, 1'b1, 1'b1);
        clearAll();
        cycle("amo3", 4'b0000, 1'b0, 32'h0, 1'b0, 1'b0);

        // Back-to-back AMO swaps on a zero word.
        doReset();
        applyStimulus(0, 1'b1, 32'h30, 4'd1, 1'b0, 32'hA);
        applyStimulus(3, 1'b1, 32'h30, 4'd1, 1'b0, 32'hB);
        cycle("swap0", 4'b0001, 1'b1, 32'h0, 1'b1, 1'b1);
        applyStimulus(0, 1'b0, 32'h0, 4'd0, 1'b0, 32'h0);
        cycle("swap1", 4'b0000, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle("swap2", 4'b1000, 1'b1, 32'hA, 1'b1, 1'b1);
        clearAll();
        cycle("swap3", 4'b0000, 1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1, 1'b1, 32'h30, 4'd0, 1'b0, 32'h0);
        cycle("swap4", 4'b0010, 1'b1, 32'hB, 1'b1, 1'b1);
        clearAll();
        cycle("swap5", 4'b0000, 1'b0, 32'h0, 1'b0, 1'b0);

        // Shim back-pressure, then pointer wrap (pointer is 2 here).
        applyStimulus(3, 1'b1, 32'h10, 4'd0, 1'b0, 32'h0);
        out_gnt_i = 1'b0;
        cycle("stall", 4'b0000, 1'b1, 32'h0, 1'b0, 1'b0);
        out_gnt_i = 1'b1;
        cycle("wrap0", 4'b1000, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
        applyStimulus(3, 1'b0, 32'h0, 4'd0, 1'b0, 32'h0);
        applyStimulus(0, 1'b1, 32'h10, 4'd0, 1'b0, 32'h0);
        applyStimulus(2, 1'b1, 32'h10, 4'd0, 1'b0, 32'h0);
        cycle("wrap1", 4'b0001, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
        applyStimulus(0, 1'b0, 32'h0, 4'd0, 1'b0, 32'h0);
        cycle("wrap2", 4'b0100, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
        clearAll();
        cycle("wrap3", 4'b0000, 1'b0, 32'h0, 1'b0, 1'b0);

        // Reset during AmoWait (pointer is 3): response dropped, priority back to port 0.
        applyStimulus(2, 1'b1, 32'h20, 4'd1, 1'b0, 32'h55);
        cycle("rst0", 4'b0100, 1'b1, 32'h0, 1'b0, 1'b0);
        clearAll();
        rst_ni = 1'b0;
        cycle("rst1", 4'b0000, 1'b0, 32'h0, 1'b0, 1'b0);
        rst_ni = 1'b1;
        cycle("rst2", 4'b0000, 1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1, 1'b1, 32'h20, 4'd0, 1'b0, 32'h0);
        applyStimulus(3, 1'b1, 32'h10, 4'd0, 1'b0, 32'h0);
        cycle("rst3", 4'b0010, 1'b1, 32'h55, 1'b1, 1'b1);
        applyStimulus(1, 1'b0, 32'h0, 4'd0, 1'b0, 32'h0);
        cycle("rst4", 4'b1000, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
        clearAll();
        cycle("rst5", 4'b0000, 1'b0, 32'h0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
